ram_responder: RTL and testbench
================================

RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 Parameter: BOOT_LOAD, default 1, 1 = leave reset in HOLD awaiting a program load; 0 = leave reset in RUN.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock shared with the processor.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 ram_addr  input  8  processor memory address (MAR output).
REQ-006 ram_data  input  8  processor write data (MBR output).
REQ-007 ram_we  input  1  processor write strobe.
REQ-008 ram_out  output  8  read data returned to the processor.
REQ-009 ld_start  input  1  one-cycle request to begin a program load.
REQ-010 ld_base  input  8  first load address, sampled with ld_start.
REQ-011 ld_len  input  8  byte count, sampled with ld_start; 0 means 256.
REQ-012 ld_valid  input  1  loader byte valid.
REQ-013 ld_data  input  8  loader byte.
REQ-014 ld_ready  output  1  block accepts a loader byte this cycle.
REQ-015 ld_done  output  1  one-cycle pulse after the last load byte is accepted.
REQ-016 cpu_hold  output  1  processor must stall; high in HOLD and LOAD.
REQ-017 wr_count  output  8  count of accepted processor writes, saturating.

Function
REQ-018 Storage SHALL be 256 x 8, addressed modulo 256; contents SHALL NOT be cleared by reset.
REQ-019 FSM SHALL have three states: HOLD, LOAD, RUN.
REQ-020 Transitions SHALL be: HOLD --ld_start--> LOAD; RUN --ld_start--> LOAD; LOAD --last byte accepted--> RUN.
REQ-021 ld_start SHALL be ignored while in LOAD.
REQ-022 In RUN, ram_out SHALL equal mem[ram_addr] combinationally (zero read latency), so a processor MBR capture in the cycle after its MAR update sees current data.
REQ-023 In HOLD and LOAD, ram_out SHALL be 8'h00.
REQ-024 In RUN, with ram_we=1, mem[ram_addr] SHALL take ram_data at the rising edge; the written value SHALL be visible on ram_out from the next cycle.
REQ-025 ram_we SHALL be ignored in HOLD and LOAD (no write, no count).
REQ-026 On the edge that enters LOAD: the load pointer SHALL take ld_base; the remaining count SHALL take ld_len (256 when ld_len=0); wr_count SHALL be cleared.
REQ-027 ld_ready SHALL be 1 exactly while in LOAD and 0 otherwise.
REQ-028 A byte SHALL be accepted on each edge with ld_valid=1 and ld_ready=1: mem[pointer] takes ld_data, the pointer increments with wrap 8'hFF->8'h00, and remaining decrements.
REQ-029 ld_valid=0 in LOAD SHALL stall without side effects; ld_data is don't-care while ld_valid=0.
REQ-030 When the accepted byte is the last (remaining=1), the next state SHALL be RUN; ld_done SHALL be 1 for that following cycle only.
REQ-031 ld_ready and cpu_hold SHALL be 0 in the cycle after the last byte is accepted.
REQ-032 wr_count SHALL increment on each accepted processor write and hold at 8'hFF.

Reset
REQ-033 While rst_n=0, these outputs SHALL hold: ld_ready=0, ld_done=0, wr_count=0, ram_out=0.
REQ-034 While rst_n=0, cpu_hold SHALL be 1 if BOOT_LOAD=1; with BOOT_LOAD=0, cpu_hold SHALL be 0 and ram_out SHALL follow REQ-022 after reset release.
REQ-035 Reset asserted mid-load SHALL abort the load immediately: state returns to HOLD/RUN per BOOT_LOAD, the pointer and remaining count are cleared, and bytes already written are retained.

Verification
REQ-036 BOOT_LOAD=1, reset, ld_start with base=8'h00, len=3, bytes A1,B2,C3 back-to-back -> ld_done pulses once, cpu_hold falls, and ram_addr=0..2 reads A1,B2,C3.
REQ-037 Load with base=8'hFE, len=4, bytes 11,22,33,44 and ld_valid gapped every other cycle -> mem[FE]=11, mem[FF]=22, mem[00]=33, mem[01]=44, and ld_ready stays high through the gaps.
REQ-038 RUN, ram_we=1, addr=8'h40, data=8'h5A for one cycle -> next cycle ram_out=5A at addr 40 and wr_count=1; 300 writes -> wr_count=FF.
REQ-039 ram_we=1 held during LOAD at addr 8'h40 -> mem[40] unchanged and wr_count=0; a second ld_start mid-load -> ignored, and the load completes with the original len.
REQ-040 rst_n low after 2 of 5 bytes (base 8'h10) -> ld_ready=0 and cpu_hold=1 at once; after release, new ld_start len=1 loads, and mem[10..11] keep the earlier bytes.
REQ-041 ld_len=0 with 256 bytes -> exactly 256 acceptances, then ld_done; pointer wrap verified at every address.

Source files
------------

// File: rtl/ram_responder.sv
// 256x8 processor RAM with a streaming program loader.
// The processor is held off while a program image is loaded.
module ram_responder #(
  parameter bit BOOT_LOAD = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ram_addr,
  input  logic [7:0] ram_data,
  input  logic       ram_we,
  output logic [7:0] ram_out,
  input  logic       ld_start,
  input  logic [7:0] ld_base,
  input  logic [7:0] ld_len,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  output logic       ld_done,
  output logic       cpu_hold,
  output logic [7:0] wr_count
);

  // state | meaning
  // HOLD  | idle after reset, processor stalled, waiting for ld_start
  // LOAD  | accepting loader bytes into memory, processor stalled
  // RUN   | processor owns the memory
  typedef enum logic [1:0] {HOLD, LOAD, RUN} state_t;

  localparam state_t RESET_STATE = BOOT_LOAD ? HOLD : RUN;

  state_t     state;
  logic [7:0] ptr;
  logic [8:0] remaining;
  logic [7:0] mem [256];

  logic run_we;
  logic load_accept;
  logic last_byte;

  assign run_we      = (state == RUN) && ram_we;
  assign load_accept = (state == LOAD) && ld_valid;
  assign last_byte   = load_accept && (remaining == 9'd1);

  assign ld_ready = (state == LOAD);
  assign cpu_hold = (state != RUN);
  // Zero-latency read so an MBR capture right after the MAR update sees current data.
  assign ram_out  = ((state == RUN) && rst_n) ? mem[ram_addr] : 8'h00;

  // Memory contents survive reset, so this block has no reset branch.
  always_ff @(posedge clk) begin
    if (run_we)
      mem[ram_addr] <= ram_data;
    else if (load_accept)
      mem[ptr] <= ld_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RESET_STATE;
      ptr       <= 8'h00;
      remaining <= 9'd0;
      ld_done   <= 1'b0;
      wr_count  <= 8'h00;
    end else begin
      ld_done <= 1'b0;
      case (state)
        HOLD, RUN: begin
          if (ld_start) begin
            state     <= LOAD;
            ptr       <= ld_base;
            remaining <= {(ld_len == 8'h00), ld_len};
            wr_count  <= 8'h00;
          end else if (run_we && (wr_count != 8'hFF)) begin
            wr_count <= wr_count + 8'h01;
          end
        end
        LOAD: begin
          if (load_accept) begin
            ptr       <= ptr + 8'h01;
            remaining <= remaining - 9'd1;
            if (last_byte) begin
              state   <= RUN;
              ld_done <= 1'b1;
            end
          end
        end
        default: state <= RESET_STATE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Directed self-checking bench for ram_responder (BOOT_LOAD=1).
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_ram_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ram_addr;
  logic [7:0] ram_data;
  logic       ram_we;
  logic [7:0] ram_out;
  logic       ld_start;
  logic [7:0] ld_base;
  logic [7:0] ld_len;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       ld_done;
  logic       cpu_hold;
  logic [7:0] wr_count;

  int tests = 0;
  int fails = 0;

  ram_responder #(.BOOT_LOAD(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_out(ram_out),
    .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_done(ld_done), .cpu_hold(cpu_hold), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [7:0] base, input logic [7:0] len);
    ld_start = 1'b1; ld_base = base; ld_len = len;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ram_addr = 8'h00; ram_data = 8'h00; ram_we = 1'b0;
    ld_start = 1'b0; ld_base = 8'h00; ld_len = 8'h00; ld_valid = 1'b0; ld_data = 8'h00;
    tick(); tick();
    tests++; if (ld_ready !== 1'b0) begin fails++; $display("FAIL rst_ld_ready got %b exp 0", ld_ready); end
    tests++; if (ld_done !== 1'b0) begin fails++; $display("FAIL rst_ld_done got %b exp 0", ld_done); end
    tests++; if (wr_count !== 8'h00) begin fails++; $display("FAIL rst_wr_count got %h exp 00", wr_count); end
    tests++; if (ram_out !== 8'h00) begin fails++; $display("FAIL rst_ram_out got %h exp 00", ram_out); end
    tests++; if (cpu_hold !== 1'b1) begin fails++; $display("FAIL rst_cpu_hold got %b exp 1", cpu_hold); end
    rst_n = 1'b1;
    tick();
    tests++; if (cpu_hold !== 1'b1 || ram_out !== 8'h00) begin
      fails++; $display("FAIL hold_after_rst cpu_hold %b ram_out %h exp 1/00", cpu_hold, ram_out); end
  endtask

  task automatic test_basic_load();
    logic [7:0] bytes [3] = '{8'hA1, 8'hB2, 8'hC3};
    int done_cnt = 0;
    start_load(8'h00, 8'd3);
    tests++; if (ld_ready !== 1'b1 || cpu_hold !== 1'b1) begin
      fails++; $display("FAIL load_entry ld_ready %b cpu_hold %b exp 1/1", ld_ready, cpu_hold); end
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = bytes[i];
      tick();
      if (ld_done) done_cnt++;
    end
    ld_valid = 1'b0;
    tests++; if (ld_done !== 1'b1 || ld_ready !== 1'b0 || cpu_hold !== 1'b0) begin
      fails++; $display("FAIL load_finish ld_done %b ld_ready %b cpu_hold %b exp 1/0/0", ld_done, ld_ready, cpu_hold); end
    tick(); if (ld_done) done_cnt++;
    tick(); if (ld_done) done_cnt++;
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL done_pulses got %0d exp 1", done_cnt); end
    for (int i = 0; i < 3; i++) begin
      ram_addr = 8'(i); #1;
      tests++; if (ram_out !== bytes[i]) begin
        fails++; $display("FAIL basic_read addr %0d got %h exp %h", i, ram_out, bytes[i]); end
    end
  endtask

  task automatic test_gapped_load();
    logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] addrs [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    int ready_bad = 0;
    start_load(8'hFE, 8'd4);
    for (int i = 0; i < 7; i++) begin
      ld_valid = (i % 2 == 0);
      ld_data  = (i % 2 == 0) ? bytes[i/2] : 8'hEE;
      tick();
      if (i < 6 && ld_ready !== 1'b1) ready_bad++;
    end
    ld_valid = 1'b0;
    tests++; if (ready_bad != 0) begin fails++; $display("FAIL gap_ready low %0d cycles exp 0", ready_bad); end
    tests++; if (ld_done !== 1'b1) begin fails++; $display("FAIL gap_done got %b exp 1", ld_done); end
    for (int i = 0; i < 4; i++) begin
      ram_addr = addrs[i]; #1;
      tests++; if (ram_out !== bytes[i]) begin
        fails++; $display("FAIL gap_read addr %h got %h exp %h", addrs[i], ram_out, bytes[i]); end
    end
  endtask

  task automatic test_write();
    ram_we = 1'b1; ram_addr = 8'h40; ram_data = 8'h5A;
    tick();
    ram_we = 1'b0; #1;
    tests++; if (ram_out !== 8'h5A) begin fails++; $display("FAIL wr_read got %h exp 5A", ram_out); end
    tests++; if (wr_count !== 8'h01) begin fails++; $display("FAIL wr_count1 got %h exp 01", wr_count); end
    ram_we = 1'b1; ram_addr = 8'h80;
    for (int i = 1; i < 300; i++) begin
      ram_data = 8'(i);
      tick();
      if (i == 253) begin
        tests++; if (wr_count !== 8'hFE) begin fails++; $display("FAIL wr_count254 got %h exp FE", wr_count); end
      end
    end
    ram_we = 1'b0;
    tests++; if (wr_count !== 8'hFF) begin fails++; $display("FAIL wr_count_sat got %h exp FF", wr_count); end
    ram_addr = 8'h80; #1;
    tests++; if (ram_out !== 8'h2B) begin fails++; $display("FAIL wr_last got %h exp 2B", ram_out); end
  endtask

  task automatic test_load_ignores();
    start_load(8'h50, 8'd3);
    tests++; if (wr_count !== 8'h00) begin fails++; $display("FAIL ld_clr_count got %h exp 00", wr_count); end
    ram_we = 1'b1; ram_addr = 8'h40; ram_data = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = 8'(i + 1);
      ld_start = (i == 1); ld_base = 8'h90; ld_len = 8'd10;
      tick();
      if (i < 2) begin
        tests++; if (ld_ready !== 1'b1 || ld_done !== 1'b0) begin
          fails++; $display("FAIL restart_ignored step %0d ready %b done %b exp 1/0", i, ld_ready, ld_done); end
      end
    end
    ram_we = 1'b0; ld_valid = 1'b0; ld_start = 1'b0;
    tests++; if (ld_done !== 1'b1) begin fails++; $display("FAIL orig_len_done got %b exp 1", ld_done); end
    tests++; if (wr_count !== 8'h00) begin fails++; $display("FAIL ld_we_count got %h exp 00", wr_count); end
    ram_addr = 8'h40; #1;
    tests++; if (ram_out !== 8'h5A) begin fails++; $display("FAIL ld_we_mem got %h exp 5A", ram_out); end
    ram_addr = 8'h52; #1;
    tests++; if (ram_out !== 8'h03) begin fails++; $display("FAIL ld_third got %h exp 03", ram_out); end
  endtask

  task automatic test_reset_midload();
    start_load(8'h10, 8'd5);
    ld_valid = 1'b1; ld_data = 8'hA0; tick();
    ld_data = 8'hA1; tick();
    ld_valid = 1'b0;
    rst_n = 1'b0; #1;
    tests++; if (ld_ready !== 1'b0 || cpu_hold !== 1'b1) begin
      fails++; $display("FAIL abort ld_ready %b cpu_hold %b exp 0/1", ld_ready, cpu_hold); end
    tick();
    rst_n = 1'b1;
    tick();
    start_load(8'h20, 8'd1);
    ld_valid = 1'b1; ld_data = 8'h77; tick();
    ld_valid = 1'b0;
    tests++; if (ld_done !== 1'b1 || cpu_hold !== 1'b0) begin
      fails++; $display("FAIL reload_done done %b hold %b exp 1/0", ld_done, cpu_hold); end
    ram_addr = 8'h10; #1;
    tests++; if (ram_out !== 8'hA0) begin fails++; $display("FAIL keep10 got %h exp A0", ram_out); end
    ram_addr = 8'h11; #1;
    tests++; if (ram_out !== 8'hA1) begin fails++; $display("FAIL keep11 got %h exp A1", ram_out); end
    ram_addr = 8'h20; #1;
    tests++; if (ram_out !== 8'h77) begin fails++; $display("FAIL reload20 got %h exp 77", ram_out); end
  endtask

  task automatic test_len256();
    int accepted = 0;
    int bad = 0;
    start_load(8'h37, 8'd0);
    for (int i = 0; i < 256; i++) begin
      ld_valid = 1'b1; ld_data = 8'(i) ^ 8'h5A;
      if (ld_ready) accepted++;
      tick();
      if (i < 255 && (ld_ready !== 1'b1 || ld_done !== 1'b0)) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL len256_early_end %0d cycles exp 0", bad); end
    tests++; if (ld_done !== 1'b1 || accepted != 256) begin
      fails++; $display("FAIL len256_done done %b accepted %0d exp 1/256", ld_done, accepted); end
    ld_data = 8'hFF;
    tick();
    ld_valid = 1'b0;
    tests++; if (ld_ready !== 1'b0) begin fails++; $display("FAIL len256_extra ready %b exp 0", ld_ready); end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      ram_addr = 8'h37 + 8'(i); #1;
      if (ram_out !== (8'(i) ^ 8'h5A)) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL len256_contents %0d bad addresses exp 0", bad); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_gapped_load();
    test_write();
    test_load_ignores();
    test_reset_midload();
    test_len256();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
